seq_div: RTL and testbench

//  Multi-cycle restoring divider; parametrised successor to the single-cycle combinational DIV datapath component.

---
 rtl/seq_div_pkg.sv | 12 +
 rtl/seq_div.sv | 157 +++++++++++++++
 tb/tb_seq_div.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_div_pkg.sv
// Shared types for the sequential restoring divider.
// State encodings are fixed so waveforms and debug taps read the same across revisions.
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/seq_div.sv
// Multi-cycle restoring divider: unsigned or two's-complement a / b, one shift/subtract step per cycle.
// Results, busy and done are all flopped; nothing combinational reaches the outputs.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one quotient bit per cycle, bit counter DATAWIDTH-1 down to 0
// FIX   | sign correction, results registered on exit
// DONE  | one-cycle done pulse; a new start is accepted here too
module seq_div
    import seq_div_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] quot,
    output logic [DATAWIDTH-1:0] rem,
    output logic                 div_by_zero
);

    localparam int N  = DATAWIDTH;
    localparam int CW = $clog2(DATAWIDTH);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [N-1:0]   dvd_q, dvd_d;
    logic [N-1:0]   dvs_q, dvs_d;
    logic           neg_quot_q, neg_quot_d;
    logic           neg_rem_q, neg_rem_d;
    logic [N-1:0]   quot_q, quot_d;
    logic [N-1:0]   rem_q, rem_d;
    logic           dbz_q, dbz_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           accept;
    logic           a_neg, b_neg;
    logic [N-1:0]   a_mag, b_mag;
    logic [N:0]     shifted;
    logic [N-1:0]   diff;
    logic           borrow;
    logic           trial_ok;

    // Negating the most negative value yields 2^(N-1), which is the correct unsigned magnitude.
    assign a_neg = is_signed & a[N-1];
    assign b_neg = is_signed & b[N-1];
    assign a_mag = a_neg ? (~a + 1'b1) : a;
    assign b_mag = b_neg ? (~b + 1'b1) : b;

    assign accept = start & ((state_q == IDLE) | (state_q == DONE));

    // A set top bit of the shifted partial remainder always exceeds the divisor.
    assign shifted           = {acc_q, dvd_q[N-1]};
    assign {borrow, diff}    = {1'b0, shifted[N-1:0]} - {1'b0, dvs_q};
    assign trial_ok          = shifted[N] | ~borrow;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dbz_d      = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    if (b == '0) begin
                        quot_d  = '1;
                        rem_d   = a;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        acc_d      = '0;
                        dvd_d      = a_mag;
                        dvs_d      = b_mag;
                        neg_quot_d = a_neg ^ b_neg;
                        neg_rem_d  = a_neg;
                        cnt_d      = CW'(N - 1);
                        state_d    = CALC;
                    end
                end
            end

            CALC: begin
                dvd_d = {dvd_q[N-2:0], trial_ok};
                acc_d = trial_ok ? diff : shifted[N-1:0];
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            FIX: begin
                quot_d  = neg_quot_q ? (~dvd_q + 1'b1) : dvd_q;
                rem_d   = neg_rem_q ? (~acc_q + 1'b1) : acc_q;
                dbz_d   = 1'b0;
                state_d = DONE;
            end

            default: state_d = IDLE;
        endcase

        busy_d = (state_d == CALC) | (state_d == FIX);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            dbz_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dbz_q      <= dbz_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quot        = quot_q;
    assign rem         = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div: directed 8-bit table and corner sequences, then a randomized 16-bit sweep
// against an arithmetic reference model.
module tb_seq_div;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       s8 = 1'b0, sg8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, z8;
    logic [7:0] q8, r8;

    logic        s16 = 1'b0, sg16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, z16;
    logic [15:0] q16, r16;

    seq_div #(.DATAWIDTH(8)) u_div8 (
        .Clk(clk), .Rst_n(rst_n), .start(s8), .is_signed(sg8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .quot(q8), .rem(r8), .div_by_zero(z8)
    );

    seq_div #(.DATAWIDTH(16)) u_div16 (
        .Clk(clk), .Rst_n(rst_n), .start(s16), .is_signed(sg16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .quot(q16), .rem(r16), .div_by_zero(z16)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division on wide values; SV '/' and '%' truncate toward zero.
    function automatic void ref_div(input int n, input bit sg, input longint ua, input longint ub,
                                    output longint q, output longint r, output bit z);
        longint mask, sa, sb;
        mask = (longint'(1) << n) - 1;
        if (ub == 0) begin
            q = mask; r = ua; z = 1'b1;
        end else if (!sg) begin
            q = ua / ub; r = ua % ub; z = 1'b0;
        end else begin
            sa = ((ua >> (n - 1)) & 1) != 0 ? ua - (longint'(1) << n) : ua;
            sb = ((ub >> (n - 1)) & 1) != 0 ? ub - (longint'(1) << n) : ub;
            q = (sa / sb) & mask;
            r = (sa % sb) & mask;
            z = 1'b0;
        end
    endfunction

    // Issue one 8-bit divide from between edges; returns positioned in the done cycle.
    task automatic op8(input bit sg, input logic [7:0] a, input logic [7:0] b,
                       output int lat, output logic busy_first);
        sg8 = sg; a8 = a; b8 = b; s8 = 1'b1;
        @(posedge clk); #1;
        s8 = 1'b0;
        busy_first = busy8;
        lat = 1;
        while (!done8 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic op16(input bit sg, input logic [15:0] a, input logic [15:0] b, output int lat);
        sg16 = sg; a16 = a; b16 = b; s16 = 1'b1;
        @(posedge clk); #1;
        s16 = 1'b0;
        lat = 1;
        while (!done16 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    typedef struct {
        string      name;
        bit         sg;
        logic [7:0] a, b, q, r;
        bit         z;
        int         lat;
    } vec_t;

    initial begin
        vec_t       vecs[$];
        int         lat, ndone;
        logic       bf;
        logic [7:0] cq, cr;
        longint     eq, er;
        bit         ez, sg;
        logic [15:0] ra, rb;

        vecs.push_back('{"u100_7",    1'b0, 8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 10});
        vecs.push_back('{"s_m7_2",    1'b1, 8'hF9,  8'h02,  8'hFD,  8'hFF,  1'b0, 10});
        vecs.push_back('{"s_7_m2",    1'b1, 8'h07,  8'hFE,  8'hFD,  8'h01,  1'b0, 10});
        vecs.push_back('{"s_ovf",     1'b1, 8'h80,  8'hFF,  8'h80,  8'h00,  1'b0, 10});
        vecs.push_back('{"u_80_ff",   1'b0, 8'h80,  8'hFF,  8'h00,  8'h80,  1'b0, 10});
        vecs.push_back('{"u_dbz",     1'b0, 8'd5,   8'd0,   8'hFF,  8'd5,   1'b1, 1});
        vecs.push_back('{"u_clr_dbz", 1'b0, 8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 10});
        vecs.push_back('{"s_dbz",     1'b1, 8'd5,   8'd0,   8'hFF,  8'd5,   1'b1, 1});
        vecs.push_back('{"s_clr_dbz", 1'b1, 8'h81,  8'h80,  8'h00,  8'h81,  1'b0, 10});
        vecs.push_back('{"u_255_1",   1'b0, 8'hFF,  8'h01,  8'hFF,  8'h00,  1'b0, 10});
        vecs.push_back('{"u_ff_ff",   1'b0, 8'hFF,  8'hFF,  8'h01,  8'h00,  1'b0, 10});
        vecs.push_back('{"u_small",   1'b0, 8'd3,   8'd10,  8'd0,   8'd3,   1'b0, 10});

        #12;
        chk("rst_quot", q8, 8'h00);
        chk("rst_rem", r8, 8'h00);
        chk("rst_dbz", z8, 1'b0);
        chk("rst_busy", busy8, 1'b0);
        chk("rst_done", done8, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            op8(vecs[i].sg, vecs[i].a, vecs[i].b, lat, bf);
            chk({vecs[i].name, "_lat"}, lat, vecs[i].lat);
            chk({vecs[i].name, "_quot"}, q8, vecs[i].q);
            chk({vecs[i].name, "_rem"}, r8, vecs[i].r);
            chk({vecs[i].name, "_dbz"}, z8, vecs[i].z);
            chk({vecs[i].name, "_busy_early"}, bf, vecs[i].lat > 1);
            chk({vecs[i].name, "_busy_in_done"}, busy8, 1'b0);
            @(posedge clk); #1;
            chk({vecs[i].name, "_done_pulse"}, done8, 1'b0);
            chk({vecs[i].name, "_quot_held"}, q8, vecs[i].q);
        end

        // Start pulse in the middle of a busy divide must be ignored.
        sg8 = 1'b0; a8 = 8'd100; b8 = 8'd7; s8 = 1'b1;
        @(posedge clk); #1;
        s8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        a8 = 8'd200; b8 = 8'd3; s8 = 1'b1;
        @(posedge clk); #1;
        s8 = 1'b0;
        ndone = 0; cq = '0; cr = '0;
        for (int c = 0; c < 20; c++) begin
            if (done8) begin
                ndone++; cq = q8; cr = r8;
            end
            @(posedge clk); #1;
        end
        chk("busy_start_ndone", ndone, 1);
        chk("busy_start_quot", cq, 8'd14);
        chk("busy_start_rem", cr, 8'd2);

        // Back-to-back: start raised during the done cycle.
        op8(1'b0, 8'd100, 8'd7, lat, bf);
        chk("b2b_first_quot", q8, 8'd14);
        op8(1'b0, 8'd50, 8'd5, lat, bf);
        chk("b2b_lat", lat, 10);
        chk("b2b_quot", q8, 8'd10);
        chk("b2b_rem", r8, 8'd0);

        // Reset in the middle of CALC: outputs clear immediately, no done follows.
        @(posedge clk); #1;
        sg8 = 1'b0; a8 = 8'd200; b8 = 8'd3; s8 = 1'b1;
        @(posedge clk); #1;
        s8 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_quot", q8, 8'h00);
        chk("midrst_rem", r8, 8'h00);
        chk("midrst_busy", busy8, 1'b0);
        chk("midrst_done", done8, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (done8) ndone++;
        end
        chk("midrst_no_done", ndone, 0);

        // Randomized 16-bit sweep.
        for (int k = 0; k < 3000; k++) begin
            sg = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
            case ($urandom_range(0, 9))
                0:       rb = 16'h0000;
                1:       rb = 16'hFFFF;
                2:       rb = 16'($urandom_range(1, 15));
                default: rb = 16'($urandom);
            endcase
            ref_div(16, sg, longint'(ra), longint'(rb), eq, er, ez);
            op16(sg, ra, rb, lat);
            chk("rand_lat", lat, (rb == 16'h0) ? 1 : 18);
            chk("rand_quot", q16, eq[15:0]);
            chk("rand_rem", r16, er[15:0]);
            chk("rand_dbz", z16, ez);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
